// File: rtl/riscv_pkg.sv
// Shared constants for the data-side memory responder: MMIO register map and STATUS layout.
package riscv_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [3:0] MMIO_CONS_DATA = 4'h0;
  localparam logic [3:0] MMIO_STATUS    = 4'h4;
  localparam logic [3:0] MMIO_CYCLE_LO  = 4'h8;
  localparam logic [3:0] MMIO_CYCLE_HI  = 4'hC;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; head is visible the cycle after the push edge and reads as 0 when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  // When full, the pop frees the slot that the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data RAM plus MMIO window (console FIFO, STATUS, 64-bit cycle counter) behind the core's dmem port.
// Reads are combinational; writes, pushes, and counter updates commit at the rising edge.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [31:0]     dmem_wdata,
  input  logic [3:0]      dmem_wstrb,
  input  logic            dmem_we,
  input  logic            dmem_re,
  output logic [31:0]     dmem_rdata,
  output logic            cons_valid,
  output logic [7:0]      cons_data,
  input  logic            cons_ready,
  output logic            unmapped
);
  localparam int              RAM_AW    = $clog2(RAM_WORDS);
  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 4);

  logic [31:0]       ram_q [RAM_WORDS];
  logic [63:0]       cycle_q, cycle_d;
  logic [31:0]       hi_shadow_q, hi_shadow_d;
  logic              ovf_q, ovf_d;

  logic              is_ram, is_mmio;
  logic [3:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              push_req, pop, clr_ovf, set_ovf, lo_read;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [31:0]       status;

  assign is_ram   = (dmem_addr < RAM_BYTES);
  assign is_mmio  = (dmem_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
  assign mmio_off = {dmem_addr[3:2], 2'b00};
  assign ram_idx  = dmem_addr[RAM_AW+1:2];
  assign unmapped = (dmem_we | dmem_re) & ~is_ram & ~is_mmio;

  assign pop      = cons_valid & cons_ready;
  assign push_req = dmem_we & is_mmio & (mmio_off == MMIO_CONS_DATA) & dmem_wstrb[0];
  assign clr_ovf  = dmem_we & is_mmio & (mmio_off == MMIO_STATUS) & dmem_wstrb[0] & dmem_wdata[STAT_OVF];
  assign set_ovf  = push_req & fifo_full & ~pop;
  assign lo_read  = dmem_re & is_mmio & (mmio_off == MMIO_CYCLE_LO);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_cons_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .din_i   (dmem_wdata[7:0]),
    .pop_i   (pop),
    .dout_o  (cons_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign cons_valid = ~fifo_empty;

  always_comb begin
    status                                 = '0;
    status[STAT_FULL]                      = fifo_full;
    status[STAT_EMPTY]                     = fifo_empty;
    status[STAT_OVF]                       = ovf_q;
    status[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_cnt);
  end

  always_comb begin
    dmem_rdata = '0;
    if (dmem_re) begin
      if (is_ram) begin
        dmem_rdata = ram_q[ram_idx];
      end else if (is_mmio) begin
        case (mmio_off)
          MMIO_STATUS:   dmem_rdata = status;
          MMIO_CYCLE_LO: dmem_rdata = cycle_q[31:0];
          MMIO_CYCLE_HI: dmem_rdata = hi_shadow_q;
          default:       dmem_rdata = '0;
        endcase
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    cycle_d     = cycle_q + 64'd1;
    hi_shadow_d = lo_read ? cycle_q[63:32] : hi_shadow_q;
    ovf_d       = set_ovf ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      hi_shadow_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      hi_shadow_q <= hi_shadow_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wstrb[i]) ram_q[ram_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue/array reference model checked every cycle plus directed literal checks.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_we, dmem_re, cons_valid, cons_ready, unmapped;
  logic [7:0]  cons_data;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready),
    .unmapped   (unmapped)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: bytes in a queue, RAM words in a sparse array, counters as plain integers.
  logic [7:0]       mq[$];
  bit               mov;
  longint unsigned  mcyc;
  logic [31:0]      mhi;
  logic [31:0]      mram [int];
  bit               mok = 1'b0;

  function automatic logic [31:0] mstatus();
    logic [31:0] s;
    int c;
    c = mq.size();
    s = 32'(c) << 8;
    if (mov)    s = s | 32'h4;
    if (c == 0) s = s | 32'h2;
    if (c == 4) s = s | 32'h1;
    return s;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return a[31:4] == MB[31:4];
  endfunction

  always @(posedge clk) begin
    bit pop, accept, setf, clrf;
    int idx;
    logic [31:0] w;
    logic [3:0] off;
    if (rst) begin
      mq.delete();
      mov  = 1'b0;
      mcyc = 0;
      mhi  = 32'h0;
      mok  = 1'b1;
    end else if (mok) begin
      pop    = (mq.size() > 0) && cons_ready;
      accept = 1'b0;
      setf   = 1'b0;
      clrf   = 1'b0;
      off    = {dmem_addr[3:2], 2'b00};
      if (dmem_we && dmem_addr < 32'h1000) begin
        idx = int'(dmem_addr >> 2);
        if (mram.exists(idx) || dmem_wstrb == 4'hF) begin
          w = mram.exists(idx) ? mram[idx] : 32'h0;
          for (int i = 0; i < 4; i++)
            if (dmem_wstrb[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
          mram[idx] = w;
        end
      end
      if (dmem_we && in_mmio(dmem_addr) && off == 4'h0 && dmem_wstrb[0]) begin
        if (mq.size() < 4 || pop) accept = 1'b1;
        else setf = 1'b1;
      end
      if (dmem_we && in_mmio(dmem_addr) && off == 4'h4 && dmem_wstrb[0] && dmem_wdata[2])
        clrf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back(dmem_wdata[7:0]);
      if (setf) mov = 1'b1;
      else if (clrf) mov = 1'b0;
      if (dmem_re && in_mmio(dmem_addr) && off == 4'h8) mhi = mcyc[63:32];
      mcyc = mcyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    bit known;
    logic [3:0] off;
    bit is_ram, is_mm;
    if (mok) begin
      is_ram = dmem_addr < 32'h1000;
      is_mm  = in_mmio(dmem_addr);
      off    = {dmem_addr[3:2], 2'b00};
      chk("unmapped", {63'h0, unmapped}, {63'h0, (dmem_we | dmem_re) & !is_ram & !is_mm});
      chk("cons_valid", {63'h0, cons_valid}, {63'h0, mq.size() > 0});
      chk("cons_data", {56'h0, cons_data}, {56'h0, (mq.size() > 0) ? mq[0] : 8'h00});
      known = 1'b1;
      er    = 32'h0;
      if (dmem_re) begin
        if (is_ram) begin
          if (mram.exists(int'(dmem_addr >> 2))) er = mram[int'(dmem_addr >> 2)];
          else known = 1'b0;
        end else if (is_mm) begin
          case (off)
            4'h4: er = mstatus();
            4'h8: er = mcyc[31:0];
            4'hC: er = mhi;
            default: er = 32'h0;
          endcase
        end
      end
      if (known) chk("rdata", {32'h0, dmem_rdata}, {32'h0, er});
    end
  end

  task automatic bus(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic rdy);
    @(posedge clk); #1;
    rst = 1'b0; dmem_we = we; dmem_re = re; dmem_addr = a;
    dmem_wdata = d; dmem_wstrb = s; cons_ready = rdy;
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    @(posedge clk); #1;
    rst = 1'b1; dmem_we = 1'b0; dmem_re = 1'b0; cons_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; dmem_we = 1'b0; dmem_re = 1'b0; dmem_addr = 32'h0;
    dmem_wdata = 32'h0; dmem_wstrb = 4'h0; cons_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Counter from reset, and reset state.
    bus(0, 1, MB + 8, 0, 0, 0);  chk("lit_cycle0", {32'h0, dmem_rdata}, 64'd0);
    repeat (9) bus(0, 0, 0, 0, 0, 0);
    bus(0, 1, MB + 8, 0, 0, 0);  chk("lit_cycle10", {32'h0, dmem_rdata}, 64'd10);
    bus(0, 1, MB + 4, 0, 0, 0);  chk("lit_status_rst", {32'h0, dmem_rdata}, 64'h002);
    chk("lit_valid_rst", {63'h0, cons_valid}, 64'd0);
    bus(0, 1, MB + 12, 0, 0, 0); chk("lit_hi_rst", {32'h0, dmem_rdata}, 64'd0);

    // RAM byte lanes and read-during-write.
    bus(1, 0, 32'h10, 32'hAABBCCDD, 4'hF, 0);
    bus(1, 0, 32'h10, 32'h11223344, 4'h5, 0);
    bus(0, 1, 32'h10, 0, 0, 0);  chk("lit_ram_lanes", {32'h0, dmem_rdata}, 64'hAA22CC44);
    bus(1, 1, 32'h10, 32'h0, 4'hF, 0); chk("lit_ram_rdw", {32'h0, dmem_rdata}, 64'hAA22CC44);
    bus(0, 1, 32'h10, 0, 0, 0);  chk("lit_ram_after", {32'h0, dmem_rdata}, 64'h0);
    bus(1, 0, 32'h14, 32'h12345678, 4'hF, 0);

    // Unmapped accesses, including one that would alias word 4 if decode truncated.
    bus(0, 1, 32'h2000_0000, 0, 0, 0);
    chk("lit_unm", {63'h0, unmapped}, 64'd1);
    chk("lit_unm_rdata", {32'h0, dmem_rdata}, 64'd0);
    bus(1, 0, 32'h2000_0010, 32'hDEADBEEF, 4'hF, 0);
    bus(0, 1, 32'h0000_1000, 0, 0, 0); chk("lit_unm_edge", {63'h0, unmapped}, 64'd1);
    bus(0, 1, 32'h10, 0, 0, 0);  chk("lit_unm_nowrite", {32'h0, dmem_rdata}, 64'h0);

    // FIFO fill, overflow, drain, clear.
    for (int i = 0; i < 5; i++) bus(1, 0, MB, 32'h41 + i, 4'h1, 0);
    bus(0, 1, MB + 4, 0, 0, 0);  chk("lit_status_full", {32'h0, dmem_rdata}, 64'h405);
    for (int i = 0; i < 4; i++) begin
      bus(0, 0, 0, 0, 0, 1);
      chk("lit_drain", {56'h0, cons_data}, 64'h41 + i);
    end
    bus(0, 1, MB + 4, 0, 0, 1);  chk("lit_status_drained", {32'h0, dmem_rdata}, 64'h006);
    bus(1, 0, MB + 4, 32'h4, 4'h1, 0);
    bus(0, 1, MB + 4, 0, 0, 0);  chk("lit_status_clr", {32'h0, dmem_rdata}, 64'h002);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) bus(1, 0, MB, 32'h61 + i, 4'h1, 0);
    bus(1, 0, MB, 32'h5A, 4'h1, 1);
    bus(0, 1, MB + 4, 0, 0, 0);  chk("lit_status_pushpop", {32'h0, dmem_rdata}, 64'h405 & 64'h401 | 64'h004 & 64'h0);
    for (int i = 0; i < 3; i++) bus(0, 0, 0, 0, 0, 1);
    bus(0, 0, 0, 0, 0, 1);       chk("lit_last_5a", {56'h0, cons_data}, 64'h5A);
    bus(0, 0, 0, 0, 0, 0);

    // Carry into the high word: HI must show the value latched by the LO read.
    @(posedge clk); #1;
    rst = 1'b0; dmem_we = 1'b0; dmem_re = 1'b1; dmem_addr = MB + 8; cons_ready = 1'b0;
    #1;
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    release dut.cycle_q;
    mcyc = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);              chk("lit_lo_max", {32'h0, dmem_rdata}, 64'hFFFF_FFFF);
    bus(0, 1, MB + 12, 0, 0, 0); chk("lit_hi_latched", {32'h0, dmem_rdata}, 64'h0);
    bus(0, 1, MB + 8, 0, 0, 0);  chk("lit_lo_wrapped", {32'h0, dmem_rdata}, 64'h1);
    bus(0, 1, MB + 12, 0, 0, 0); chk("lit_hi_new", {32'h0, dmem_rdata}, 64'h1);
    bus(1, 0, MB + 12, 32'h77, 4'hF, 0);
    bus(0, 1, MB + 12, 0, 0, 0); chk("lit_hi_ro", {32'h0, dmem_rdata}, 64'h1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) bus(1, 0, MB, 32'h30 + i, 4'h1, 0);
    bus(0, 0, 0, 0, 0, 1);
    reset_cycle();
    bus(0, 1, MB + 4, 0, 0, 1);
    chk("lit_status_midrst", {32'h0, dmem_rdata}, 64'h002);
    chk("lit_valid_midrst", {63'h0, cons_valid}, 64'd0);
    bus(0, 1, 32'h14, 0, 0, 0);  chk("lit_ram_kept", {32'h0, dmem_rdata}, 64'h12345678);
    bus(0, 1, MB + 8, 0, 0, 0);  chk("lit_cycle_restart", {32'h0, dmem_rdata}, 64'd2);
    bus(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
